// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side strobe and consumer-side pop bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_W-1:0]     i_rx_d;
  logic                  i_rx_complete;
  logic                  i_rx_error;
  logic                  i_rd_en;
  logic                  i_ovf_clr;
  logic [DATA_W-1:0]     o_rd_d;
  logic                  o_rd_err;
  logic                  o_empty;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_overflow;
  logic                  o_err_drop;

  modport master (
    output i_rx_d, i_rx_complete, i_rx_error, i_rd_en, i_ovf_clr,
    input  o_rd_d, o_rd_err, o_empty, o_full, o_count, o_overflow, o_err_drop
  );

  modport slave (
    input  i_rx_d, i_rx_complete, i_rx_error, i_rd_en, i_ovf_clr,
    output o_rd_d, o_rd_err, o_empty, o_full, o_count, o_overflow, o_err_drop
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO behind the UART receiver
// Define UART_RX_FIFO_ERR_TAG_EN to store errored frames with a tag bit instead of dropping them.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  empty;
  logic                  full;
  logic                  accept;
  logic                  push_req;
  logic                  pop;
  logic                  wr_ok;
  logic                  drop;
  logic                  err_hit;
  logic [MEM_W-1:0]      wdata;
  logic [MEM_W-1:0]      head;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign accept  = 1'b1;
  assign err_hit = 1'b0;
  assign wdata   = {bus.i_rx_error, bus.i_rx_d};
`else
  assign accept  = ~bus.i_rx_error;
  assign err_hit = bus.i_rx_complete & bus.i_rx_error;
  assign wdata   = bus.i_rx_d;
`endif

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign push_req = bus.i_rx_complete & accept;
  assign pop      = bus.i_rd_en & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_ok    = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)               overflow <= 1'b1;
      else if (bus.i_ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign bus.o_err_drop = 1'b0;
  assign bus.o_rd_err   = empty ? 1'b0 : head[DATA_W];
  logic unused_err;
  assign unused_err = err_hit;
`else
  logic err_drop;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                err_drop <= 1'b0;
    else if (err_hit)       err_drop <= 1'b1;
    else if (bus.i_ovf_clr) err_drop <= 1'b0;
  end
  assign bus.o_err_drop = err_drop;
  assign bus.o_rd_err   = 1'b0;
`endif

  assign head           = mem[rd_ptr];
  assign bus.o_rd_d     = empty ? '0 : head[DATA_W-1:0];
  assign bus.o_empty    = empty;
  assign bus.o_full     = full;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer placed directly downstream of the UART receiver. Captures each byte the receiver reports on its one-cycle completion strobe, stores it in a first-word-fall-through FIFO, and presents it to the consuming logic through a simple valid/pop interface. Flags overflow when the consumer falls behind the 115200-baud line rate and handles frames the receiver marks as errored.

## Interface
- DATA_W, 8, byte width; matches receiver data output
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16)
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- i_rx_d  in  DATA_W  received byte; sampled only when i_rx_complete = 1
- i_rx_complete  in  1  one-cycle strobe, one per received frame
- i_rx_error  in  1  frame error for the current strobe; qualified by i_rx_complete
- i_rd_en  in  1  pop request; ignored while o_empty = 1
- i_ovf_clr  in  1  clears o_overflow
- o_rd_d  out  DATA_W  head-of-FIFO byte; forced to 0 while empty
- o_rd_err  out  1  error tag of head byte (UART_RX_FIFO_ERR_TAG_EN only); 0 while empty
- o_empty  out  1  FIFO holds no bytes
- o_full  out  1  FIFO holds DEPTH bytes
- o_count  out  DEPTH_LOG2+1  bytes held, 0..DEPTH
- o_overflow  out  1  sticky: a push was dropped because the FIFO was full
- o_err_drop  out  1  sticky: an errored frame was discarded (macro absent only; tied 0 otherwise)

## Operation
- Storage: DEPTH-entry array, write pointer and read pointer of DEPTH_LOG2 bits each, wrapping modulo DEPTH; occupancy held in a separate DEPTH_LOG2+1-bit counter, not derived from pointers.
- push = i_rx_complete & accept, where accept depends on the macro (see Configuration).
- pop = i_rd_en & ~o_empty.
- Push when not full: write at wr_ptr, wr_ptr+1.
- Push when full with simultaneous pop: accepted; count unchanged.
- Push when full without pop: byte dropped, pointers and count unchanged, o_overflow <= 1.
- Pop when empty: ignored; simultaneous push stores the byte normally (no bypass).
- Push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- o_overflow: set on drop; cleared by i_ovf_clr; set wins if both occur in the same cycle. o_err_drop follows identical rules and is also cleared by i_ovf_clr.
- o_empty = (count == 0); o_full = (count == DEPTH).
- No state machine beyond pointer/counter control; no error, busy or reset-in-progress states.

## Timing
- All state updates on rising clk; rst asynchronous, deassertion synchronous to clk via external synchronizer.
- Reset values: o_rd_d 0, o_rd_err 0, o_empty 1, o_full 0, o_count 0, o_overflow 0, o_err_drop 0, pointers 0. Array contents are not reset.
- Write latency: byte strobed at edge N is on o_rd_d and o_empty = 0 immediately after edge N (one cycle).
- Pop: i_rd_en high at edge N retires head; next entry (or 0 if empty) on o_rd_d after edge N.
- o_rd_d, o_rd_err, flags and count are combinational from registered state only; no input-to-output combinational path.
- Reset mid-stream: all stored bytes discarded; strobe coincident with rst is lost.

## Configuration
- UART_RX_FIFO_ERR_TAG_EN defined: array is DATA_W+1 bits wide; errored frames are stored with tag bit = i_rx_error, surfaced on o_rd_err with its byte; o_err_drop tied 0.
- Not defined: array is DATA_W bits; strobes with i_rx_error = 1 are not pushed, o_err_drop <= 1; o_rd_err tied 0.

## Test plan
- Reset, strobe 0x55 once -> next cycle o_rd_d = 0x55, o_empty = 0, o_count = 1; pop -> o_empty = 1, o_rd_d = 0.
- Push 0x00..0x0F with no pops -> o_full = 1, o_count = 16; push 0xAA -> o_overflow = 1, pops return 0x00..0x0F in order; 0xAA never appears.
- At full, push 0x77 with pop in same cycle -> o_count stays 16, o_overflow stays 0, 0x77 emerges 16th.
- Push 20 bytes interleaved with pops across pointer wrap -> output sequence identical to input, o_count never exceeds 16.
- Strobe 0x3C with i_rx_error = 1 -> macro defined: o_rd_d = 0x3C, o_rd_err = 1; macro undefined: o_empty stays 1, o_err_drop = 1; i_ovf_clr -> 0.
- Assert rst with 5 bytes held -> o_count = 0, o_empty = 1, o_overflow = 0 asynchronously, before next clk edge.
